// File: rtl/parity_nibble_checker_if.sv
// parity_nibble_checker_if
//   Bundles the serial input handshake, the resync control and the checked
//   nibble output handshake of parity_nibble_checker.
//   Modports:
//     master : the environment (bit source + nibble consumer)
//     slave  : the checker itself
//   Signals:
//     in_valid, in_bit, in_ready : serial bit handshake
//     resync                     : abort the partial frame
//     out_valid, out_data,
//     out_err, out_ready         : checked nibble handshake
interface parity_nibble_checker_if;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       resync;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_err;
  logic       out_ready;

  modport master (
    output in_valid, in_bit, resync, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_bit, resync, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/parity_nibble_checker.sv
// parity_nibble_checker
//   Deserialises 5-bit frames (x0..x3 LSB first, then the parity bit),
//   recomputes parity and holds the nibble plus a pass/fail flag in a
//   one-deep valid/ready output register.
//   Parameters:
//     ODD_PARITY : 0 = expected parity is x0^x1^x2^x3, 1 = its inverse
//     CNT_W      : width of the optional saturating error counter
//   Ports:
//     clk     : rising-edge clock
//     rst     : synchronous active-high reset
//     bus     : parity_nibble_checker_if.slave (serial in, resync, nibble out)
//     err_cnt : saturating count of failed frames (only with the macro)
//   Optional feature macro: PARITY_ERR_CNT_EN enables err_cnt.
module parity_nibble_checker #(
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  parity_nibble_checker_if.slave    bus
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]          err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_D0  = 3'd0,
    S_D1  = 3'd1,
    S_D2  = 3'd2,
    S_D3  = 3'd3,
    S_PAR = 3'd4
  } state_t;

  state_t     state;
  logic [3:0] sr;
  logic       out_valid_q;
  logic [3:0] out_data_q;
  logic       out_err_q;
  logic       in_ready_c;
  logic       xfer;
  logic       drain;

  // 1 = parity bit disagrees with the expected value for this nibble.
  function automatic logic parity_err(input logic [3:0] d, input logic p);
    return p ^ (^d) ^ ODD_PARITY;
  endfunction

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign err_cnt = err_cnt_q;
`endif

  // Only the parity bit can stall, and only while a held result is not draining.
  assign in_ready_c = !((state == S_PAR) && out_valid_q && !bus.out_ready);
  assign xfer       = bus.in_valid && in_ready_c;
  assign drain      = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_D0;
      sr          <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 4'd0;
      out_err_q   <= 1'b0;
`ifdef PARITY_ERR_CNT_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      // A drain empties the register unless a new result replaces it below.
      if (drain) out_valid_q <= 1'b0;

      if (bus.resync) begin
        // Abort wins over any bit transferred this cycle, including parity.
        state <= S_D0;
        sr    <= 4'd0;
      end else if (xfer) begin
        unique case (state)
          S_D0: begin sr[0] <= bus.in_bit; state <= S_D1; end
          S_D1: begin sr[1] <= bus.in_bit; state <= S_D2; end
          S_D2: begin sr[2] <= bus.in_bit; state <= S_D3; end
          S_D3: begin sr[3] <= bus.in_bit; state <= S_PAR; end
          S_PAR: begin
            out_data_q  <= sr;
            out_err_q   <= parity_err(sr, bus.in_bit);
            out_valid_q <= 1'b1;
            state       <= S_D0;
`ifdef PARITY_ERR_CNT_EN
            if (parity_err(sr, bus.in_bit)) err_cnt_q <= sat_inc(err_cnt_q);
`endif
          end
          default: state <= S_D0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_nibble_checker.sv
module tb_parity_nibble_checker;
  localparam bit ODD   = 1'b0;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parity_nibble_checker_if bus();
`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt;
`endif

  parity_nibble_checker #(.ODD_PARITY(ODD), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef PARITY_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  typedef struct packed {
    logic [3:0] d;
    logic       e;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  bit   bits_q[$];
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock of stimulus; the reference model consumes the same inputs.
  task automatic cycle(input bit v, input bit b, input bit rs, input bit ordy);
    bit         rdy;
    logic [3:0] d;
    int         ones;
    bit         e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_bit    = b;
    bus.resync    = rs;
    bus.out_ready = ordy;
    #1;
    rdy = !(bits_q.size() == 4 && exp_q.size() > 0 && !ordy);
    chk("in_ready", bus.in_ready, rdy);
`ifdef PARITY_ERR_CNT_EN
    chk("err_cnt", err_cnt, exp_cnt);
`endif
    if (rs) begin
      bits_q.delete();
    end else if (v && rdy) begin
      bits_q.push_back(b);
      if (bits_q.size() == 5) begin
        ones = 0;
        for (int i = 0; i < 5; i++) ones += bits_q[i];
        for (int i = 0; i < 4; i++) d[i] = bits_q[i];
        // Even parity: the five received bits must contain an even count of ones.
        e = ((ones % 2) == 1) ^ ODD;
        exp_q.push_back('{d: d, e: e});
        if (e && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        bits_q.delete();
      end
    end
  endtask

  task automatic send_frame(input logic [3:0] d, input bit p, input bit ordy);
    for (int i = 0; i < 4; i++) cycle(1'b1, d[i], 1'b0, ordy);
    cycle(1'b1, p, 1'b0, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.resync   = 1'b0;
    exp_q.delete();
    bits_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 4'h0);
    chk("rst_out_err", bus.out_err, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
`ifdef PARITY_ERR_CNT_EN
    chk("rst_err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
  endtask

  // Monitor: checks the held nibble every cycle it is presented, pops on drain.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out actual=%0h required=none", bus.out_data);
        end else begin
          chk("out_data", bus.out_data, exp_q[0].d);
          chk("out_err", bus.out_err, exp_q[0].e);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.resync    = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();

    // Bits 1,0,1,1 then good parity -> 4'b1101, no error.
    send_frame(4'b1101, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("tp_valid", bus.out_valid, 1'b1);
    chk("tp_data", bus.out_data, 4'hd);
    chk("tp_err", bus.out_err, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Same data with bad parity.
    send_frame(4'b1101, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Resync after two bits, then a clean zero frame.
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(4'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-pressure: A held, B's parity stalls until A drains.
    send_frame(4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, i[0] ? 1'b0 : 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("bp_data", bus.out_data, 4'h5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 31) == 0), $urandom_range(0, 1));

    // Reset with a result held, then more traffic.
    send_frame(4'ha, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 800; i++)
      cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 31) == 0), $urandom_range(0, 1));

    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parity_nibble_checker.md
# parity_nibble_checker

Serial receive-side checker for the 4-bit parity code produced by the team's combinational parity generator, where the parity bit is x0^x1^x2^x3. It deserialises 5-bit frames (4 data bits, LSB first, then the parity bit) from a bit stream. It recomputes parity and presents the nibble with a pass/fail flag on a one-deep valid/ready output register. It sits downstream of the serial link, between the bit deserialiser and the nibble consumer.

## Interface
- ODD_PARITY, 0: 0 = even parity, so the expected parity bit is x0^x1^x2^x3; 1 = odd parity, so the expected bit is the inverse.
- CNT_W, 8: width of the optional error counter.

Ports (clock and reset first):
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_bit is valid this cycle.
- in_bit  in  1  serial data bit: data bits x0..x3 in order, then the parity bit.
- in_ready  out  1  checker accepts in_bit this cycle.
- resync  in  1  synchronous abort of the partial frame; the next accepted bit is x0.
- out_valid  out  1  a checked nibble is held.
- out_data  out  4  received x3..x0 (bit i = xi).
- out_err  out  1  1 = the received parity bit mismatches the expected value.
- out_ready  in  1  consumer takes the held nibble this cycle.
- err_cnt  out  CNT_W  saturating count of frames with out_err=1. Present only with the macro.

## Operation
- A bit transfers when in_valid && in_ready.
- FSM states:
  - S_D0..S_D3: collect data bit i into shift register `sr[i]`.
  - S_PAR: the next transfer is the parity bit.
  - Each transfer advances S_D0 → S_D1 → S_D2 → S_D3 → S_PAR → S_D0. There is no idle state; the block waits in the current state while no transfer occurs.
- On a parity transfer:
  - out_data ← sr.
  - out_err ← in_bit ^ (sr[0]^sr[1]^sr[2]^sr[3]) ^ ODD_PARITY.
  - out_valid ← 1.
  - The FSM returns to S_D0.
- out_valid clears on out_valid && out_ready, unless a parity transfer occurs in the same cycle. In that case the new nibble loads and out_valid stays 1.
- in_ready = !(state==S_PAR && out_valid && !out_ready).
  - Data bits are never stalled.
  - A parity bit stalls only when the output register is full and not draining, so a held result is never overwritten or lost.
- resync:
  - Forces state to S_D0 and clears sr.
  - Any in_bit transferred in the same cycle is discarded.
  - It does not touch out_valid, out_data, out_err or err_cnt.
  - resync has priority over the parity-completion path.
- Arithmetic:
  - Parity is a 4-input XOR plus a parameter inversion.
  - err_cnt increments by 1 when a frame completes with out_err=1, and saturates at 2^CNT_W−1 (no wrap).

## Timing
- Reset values:
  - state=S_D0, sr=0.
  - out_valid=0, out_data=0, out_err=0.
  - err_cnt=0.
  - in_ready=1 (combinational from the reset state).
- Latency: out_valid rises on the edge that accepts the parity bit, so the result is visible the cycle after the parity transfer.
- Throughput: one frame per 5 accepted bits with no bubbles when out_ready=1.
- out_data and out_err stay stable while out_valid=1 && out_ready=0.
- rst mid-frame discards the partial frame and any held output. rst overrides resync and all transfers.
- Simultaneous drain and parity transfer: the consumer takes the old nibble and the new nibble is loaded on the same edge.

## Configuration
- PARITY_ERR_CNT_EN
  - Defined: the err_cnt port and the saturating counter exist.
  - Undefined: the port and its logic are removed; all other behaviour is identical.

## Test plan
- After reset, send bits 1,0,1,1 then parity 1 with out_ready=1 and ODD_PARITY=0 → next cycle out_valid=1, out_data=4'b1101, out_err=0.
- Same data with parity 0 → out_err=1; err_cnt goes 0 → 1 (macro defined).
- Hold out_ready=0 after frame A (data 4'h3, parity 0), then stream frame B (data 4'h5) → in_ready=0 in S_PAR. Out_data stays 4'h3. Raising out_ready drains A, then B's parity is accepted and out_data=4'h5.
- After 2 data bits (1,1), pulse resync while in_valid=1, then send 0,0,0,0 and parity 0 → out_data=4'h0, out_err=0; no stale bits.
- Assert rst mid-frame with out_valid=1 → next cycle out_valid=0, out_data=0, state S_D0, err_cnt=0.
- With CNT_W=2, send 5 bad-parity frames → err_cnt reads 1, 2, 3, 3, 3.
